// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 pooling (floor average or max) over a raster-order pixel stream.
// Only a half-row buffer of column-pair partials is kept between the two rows of a window.
module pool2x2_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int IDX_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     busy
);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int LW    = (CW > 1) ? CW - 1 : 1;
    localparam int N_OUT = (IMG_W / 2) * (IMG_H / 2);
    localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);

    logic                     rdy_en;
    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic signed [DATA_W-1:0] hold;
    logic                     mode_q;
    logic signed [DATA_W:0]   linebuf [2**LW];

    logic                     accept;
    logic                     out_fire;
    logic [LW-1:0]            lb_sel;
    logic signed [DATA_W-1:0] pair_max;
    logic signed [DATA_W:0]   pair_sum;
    logic signed [DATA_W:0]   partial;
    logic signed [DATA_W:0]   lb_rd;
    logic signed [DATA_W:0]   quad_max;
    logic signed [DATA_W+1:0] quad_sum;
    logic signed [DATA_W-1:0] result;

    // start blocks acceptance so the pixel offered alongside it is never consumed
    assign in_ready = rdy_en && !start && !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign out_last = (out_idx == IDX_LAST);

    assign lb_sel   = LW'(col >> 1);
    assign lb_rd    = linebuf[lb_sel];

    assign pair_sum = {hold[DATA_W-1], hold} + {in_data[DATA_W-1], in_data};
    assign pair_max = (in_data > hold) ? in_data : hold;
    assign partial  = mode_q ? {pair_max[DATA_W-1], pair_max} : pair_sum;

    // arithmetic shift of the 4-pixel sum floors toward -inf and always fits DATA_W
    assign quad_sum = {partial[DATA_W], partial} + {lb_rd[DATA_W], lb_rd};
    assign quad_max = (partial > lb_rd) ? partial : lb_rd;
    assign result   = mode_q ? DATA_W'(quad_max) : DATA_W'(quad_sum >>> 2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en    <= 1'b0;
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (start) begin
                col       <= '0;
                row       <= '0;
                out_valid <= 1'b0;
                out_idx   <= '0;
                busy      <= 1'b0;
            end else begin
                if (out_fire) begin
                    out_valid <= 1'b0;
                    out_idx   <= out_last ? '0 : out_idx + IDX_W'(1);
                    if (out_last) begin
                        busy <= 1'b0;
                    end
                end
                if (accept) begin
                    if (col == '0 && row == '0) begin
                        mode_q <= mode;
                        busy   <= 1'b1;
                    end
                    if (!col[0]) begin
                        hold <= in_data;
                    end else if (row[0]) begin
                        out_valid <= 1'b1;
                        out_data  <= result;
                    end
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
            end
        end
    end

    // row 0 of every frame rewrites each entry before row 1 reads it, so no reset is needed
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) begin
            linebuf[lb_sel] <= partial;
        end
    end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream: a 4x4 instance for latency/back-pressure/start/back-to-back
// scenarios and a default 28x28 instance for full-frame max/avg and mid-frame reset.
`timescale 1ns/1ps
module tb_pool2x2_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int d;
        int idx;
        bit last;
    } out_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic              a_rst = 1'b0, a_start = 1'b0, a_mode = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic signed [7:0] a_in_data = '0;
    logic              a_in_ready, a_out_valid, a_out_last, a_busy;
    logic signed [7:0] a_out_data;
    logic [7:0]        a_out_idx;

    logic              b_rst = 1'b0, b_start = 1'b0, b_mode = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic signed [7:0] b_in_data = '0;
    logic              b_in_ready, b_out_valid, b_out_last, b_busy;
    logic signed [7:0] b_out_data;
    logic [7:0]        b_out_idx;

    pool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .IDX_W(8)) dut_a (
        .clk(clk), .reset(a_rst), .start(a_start), .mode(a_mode),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_idx(a_out_idx), .out_last(a_out_last), .busy(a_busy)
    );

    pool2x2_stream #(.DATA_W(8), .IMG_W(28), .IMG_H(28), .IDX_W(8)) dut_b (
        .clk(clk), .reset(b_rst), .start(b_start), .mode(b_mode),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_idx(b_out_idx), .out_last(b_out_last), .busy(b_busy)
    );

    out_t aq[$];
    out_t bq[$];
    out_t mon_a, mon_b;
    int   pix[784];

    // inputs change at posedge+1, so the negedge sees a settled handshake
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            mon_a.d = int'(a_out_data); mon_a.idx = int'(a_out_idx); mon_a.last = a_out_last;
            aq.push_back(mon_a);
        end
        if (b_out_valid && b_out_ready) begin
            mon_b.d = int'(b_out_data); mon_b.idx = int'(b_out_idx); mon_b.last = b_out_last;
            bq.push_back(mon_b);
        end
    end

    function automatic void fill_pix(input int m, input int a);
        for (int i = 0; i < 784; i++) begin
            int t;
            t = ((i * m + a) ^ (i >> 3)) & 255;
            pix[i] = (t >= 128) ? t - 256 : t;
        end
    endfunction

    function automatic int model_b(input int oi, input bit md);
        int base, v0, v1, v2, v3, m01, m23;
        base = 2 * (oi / 14) * 28 + 2 * (oi % 14);
        v0 = pix[base]; v1 = pix[base + 1]; v2 = pix[base + 28]; v3 = pix[base + 29];
        if (md) begin
            m01 = (v0 > v1) ? v0 : v1;
            m23 = (v2 > v3) ? v2 : v3;
            return (m01 > m23) ? m01 : m23;
        end
        return (v0 + v1 + v2 + v3) >>> 2;
    endfunction

    task automatic send_px_a(input int px[32], input int n, input bit md0, input bit md1);
        int p = 0, guard = 0;
        a_out_ready = 1'b1;
        while (p < n && guard < 400) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1;
            a_in_data  = 8'(px[p]);
            a_mode     = (p < 16) ? md0 : md1;
            @(negedge clk);
            if (a_in_ready) p++;
            guard++;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (p != n) begin
            n_fail++;
            $display("FAIL send_a_timeout: accepted=%0d required=%0d", p, n);
        end
    endtask

    task automatic send_frame_b(input bit md, input int toggle_at);
        int p = 0, guard = 0;
        b_out_ready = 1'b1;
        while (p < 784 && guard < 3000) begin
            @(posedge clk); #1;
            b_in_valid = 1'b1;
            b_in_data  = 8'(pix[p]);
            b_mode     = (p >= toggle_at) ? !md : md;
            @(negedge clk);
            if (b_in_ready) p++;
            guard++;
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (p != 784) begin
            n_fail++;
            $display("FAIL send_b_timeout: accepted=%0d required=784", p);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_out_data !== 8'sd0 ||
            a_out_idx !== 8'd0 || a_out_last !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: ready=%b valid=%b data=%0d idx=%0d last=%b busy=%b required all 0",
                     a_in_ready, a_out_valid, a_out_data, a_out_idx, a_out_last, a_busy);
        end
        n_tests++;
        if (b_in_ready !== 1'b0 || b_out_valid !== 1'b0 || b_out_data !== 8'sd0 ||
            b_out_idx !== 8'd0 || b_out_last !== 1'b0 || b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: ready=%b valid=%b data=%0d idx=%0d last=%b busy=%b required all 0",
                     b_in_ready, b_out_valid, b_out_data, b_out_idx, b_out_last, b_busy);
        end
        @(posedge clk); #1;
        a_rst = 1'b1; b_rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: in_ready=%b required 0", a_in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: a=%b b=%b required 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_avg_basic();
        int exp_d[4] = '{2, 4, 10, 12};
        int o = 0;
        bit want;
        aq.delete();
        a_mode = 1'b0; a_out_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(posedge clk); #1;
            a_in_valid = (k < 16);
            a_in_data  = 8'(k);
            @(negedge clk);
            if (k == 1) begin
                n_tests++;
                if (a_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_rise: busy=%b required 1", a_busy);
                end
            end
            if (k >= 1) begin
                want = (k - 1 == 5) || (k - 1 == 7) || (k - 1 == 13) || (k - 1 == 15);
                n_tests++;
                if (a_out_valid !== want) begin
                    n_fail++;
                    $display("FAIL avg_latency after pixel %0d: out_valid=%b required %b", k - 1, a_out_valid, want);
                end else if (want) begin
                    n_tests++;
                    if (int'(a_out_data) != exp_d[o] || int'(a_out_idx) != o || a_out_last !== (o == 3)) begin
                        n_fail++;
                        $display("FAIL avg_basic out %0d: data=%0d idx=%0d last=%b required data=%0d idx=%0d last=%b",
                                 o, a_out_data, a_out_idx, a_out_last, exp_d[o], o, (o == 3));
                    end
                    o++;
                end
            end
        end
        @(negedge clk);
        n_tests++;
        if (a_busy !== 1'b0 || a_out_idx !== 8'd0 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_end: busy=%b idx=%0d valid=%b required 0 0 0", a_busy, a_out_idx, a_out_valid);
        end
    endtask

    task automatic test_avg_floor();
        int px[32];
        int exp_d[4] = '{-2, 127, -128, -1};
        int src[16]  = '{-1, -1, 127, 127, -1, -2, 127, 127, -128, -128, -1, 0, -128, -128, 0, 0};
        for (int i = 0; i < 32; i++) px[i] = (i < 16) ? src[i] : 0;
        aq.delete();
        send_px_a(px, 16, 1'b0, 1'b0);
        n_tests++;
        if (aq.size() != 4) begin
            n_fail++;
            $display("FAIL avg_floor_count: got %0d outputs required 4", aq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (aq[i].d != exp_d[i] || aq[i].idx != i || aq[i].last != (i == 3)) begin
                    n_fail++;
                    $display("FAIL avg_floor out %0d: data=%0d idx=%0d required data=%0d idx=%0d",
                             i, aq[i].d, aq[i].idx, exp_d[i], i);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        int p = 0, stalled = 0, guard = 0;
        bit released = 1'b0;
        int exp_d[4] = '{2, 4, 10, 12};
        aq.delete();
        a_mode = 1'b0;
        while ((p < 16 || aq.size() < 4) && guard < 300) begin
            @(posedge clk); #1;
            a_in_valid  = (p < 16);
            a_in_data   = 8'(p);
            a_out_ready = released;
            @(negedge clk);
            if (a_out_valid && !released) begin
                stalled++;
                n_tests++;
                if (a_in_ready !== 1'b0 || a_out_data !== 8'sd2 || p != 6) begin
                    n_fail++;
                    $display("FAIL bp_stall cycle %0d: in_ready=%b data=%0d accepted=%0d required 0 2 6",
                             stalled, a_in_ready, a_out_data, p);
                end
                if (stalled == 10) released = 1'b1;
            end
            if (a_in_valid && a_in_ready) p++;
            guard++;
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (aq.size() != 4 || stalled != 10) begin
            n_fail++;
            $display("FAIL bp_count: outputs=%0d stalled=%0d required 4 10", aq.size(), stalled);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (aq[i].d != exp_d[i] || aq[i].idx != i) begin
                    n_fail++;
                    $display("FAIL bp_out %0d: data=%0d idx=%0d required %0d %0d", i, aq[i].d, aq[i].idx, exp_d[i], i);
                end
            end
        end
    endtask

    task automatic test_start();
        int px[32];
        int exp_d[4] = '{2, 4, 10, 12};
        for (int i = 0; i < 32; i++) px[i] = i % 16;
        send_px_a(px, 9, 1'b0, 1'b0);
        @(posedge clk); #1;
        a_start = 1'b1; a_in_valid = 1'b1; a_in_data = 8'sd99;
        @(posedge clk); #1;
        a_start = 1'b0; a_in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b0 || a_out_idx !== 8'd0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clear: valid=%b idx=%0d busy=%b required 0 0 0", a_out_valid, a_out_idx, a_busy);
        end
        aq.delete();
        send_px_a(px, 16, 1'b0, 1'b0);
        n_tests++;
        if (aq.size() != 4) begin
            n_fail++;
            $display("FAIL start_count: got %0d outputs required 4", aq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (aq[i].d != exp_d[i] || aq[i].idx != i) begin
                    n_fail++;
                    $display("FAIL start_out %0d: data=%0d idx=%0d required %0d %0d", i, aq[i].d, aq[i].idx, exp_d[i], i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int px[32];
        int exp_d[8] = '{2, 4, 10, 12, 15, 13, 7, 5};
        for (int i = 0; i < 32; i++) px[i] = (i < 16) ? i : 31 - i;
        aq.delete();
        send_px_a(px, 32, 1'b0, 1'b1);
        n_tests++;
        if (aq.size() != 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs required 8", aq.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (aq[i].d != exp_d[i] || aq[i].idx != i % 4 || aq[i].last != (i % 4 == 3)) begin
                    n_fail++;
                    $display("FAIL b2b_out %0d: data=%0d idx=%0d last=%b required %0d %0d %b",
                             i, aq[i].d, aq[i].idx, aq[i].last, exp_d[i], i % 4, (i % 4 == 3));
                end
            end
        end
    endtask

    task automatic test_max_frame();
        fill_pix(73, 41);
        bq.delete();
        send_frame_b(1'b1, 100);
        n_tests++;
        if (bq.size() != 196) begin
            n_fail++;
            $display("FAIL max_count: got %0d outputs required 196", bq.size());
        end else begin
            for (int i = 0; i < 196; i++) begin
                n_tests++;
                if (bq[i].d != model_b(i, 1'b1) || bq[i].idx != i || bq[i].last != (i == 195)) begin
                    n_fail++;
                    $display("FAIL max_out %0d: data=%0d idx=%0d required %0d %0d", i, bq[i].d, bq[i].idx, model_b(i, 1'b1), i);
                end
            end
        end
    endtask

    task automatic test_mode_next_frame();
        fill_pix(29, 7);
        bq.delete();
        send_frame_b(1'b0, 300);
        n_tests++;
        if (bq.size() != 196) begin
            n_fail++;
            $display("FAIL mode_next_count: got %0d outputs required 196", bq.size());
        end else begin
            for (int i = 0; i < 196; i++) begin
                n_tests++;
                if (bq[i].d != model_b(i, 1'b0) || bq[i].idx != i) begin
                    n_fail++;
                    $display("FAIL mode_next_out %0d: data=%0d idx=%0d required %0d %0d", i, bq[i].d, bq[i].idx, model_b(i, 1'b0), i);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int p = 0, guard = 0;
        fill_pix(101, 3);
        b_out_ready = 1'b1;
        while (p < 90 && guard < 500) begin
            @(posedge clk); #1;
            b_in_valid = 1'b1; b_in_data = 8'(pix[p]); b_mode = 1'b0;
            @(negedge clk);
            if (b_in_valid && b_in_ready) p++;
            guard++;
        end
        @(posedge clk); #2;
        b_rst = 1'b0; b_in_valid = 1'b0;
        #1;
        n_tests++;
        if (b_in_ready !== 1'b0 || b_out_valid !== 1'b0 || b_out_data !== 8'sd0 ||
            b_out_idx !== 8'd0 || b_out_last !== 1'b0 || b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%b valid=%b data=%0d idx=%0d last=%b busy=%b required all 0 (accepted=%0d)",
                     b_in_ready, b_out_valid, b_out_data, b_out_idx, b_out_last, b_busy, p);
        end
        @(posedge clk); #1;
        b_rst = 1'b1;
        fill_pix(55, 19);
        bq.delete();
        send_frame_b(1'b0, 784);
        n_tests++;
        if (bq.size() != 196) begin
            n_fail++;
            $display("FAIL post_reset_count: got %0d outputs required 196", bq.size());
        end else begin
            for (int i = 0; i < 196; i++) begin
                n_tests++;
                if (bq[i].d != model_b(i, 1'b0) || bq[i].idx != i) begin
                    n_fail++;
                    $display("FAIL post_reset_out %0d: data=%0d idx=%0d required %0d %0d", i, bq[i].d, bq[i].idx, model_b(i, 1'b0), i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_avg_basic();
        test_avg_floor();
        test_back_pressure();
        test_start();
        test_back_to_back();
        test_max_frame();
        test_mode_next_frame();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
